frac_lutk_cfg: RTL and testbench
================================

// Module: frac_lutk_cfg
// PURPOSE
//  Parametrised fracturable K-input LUT with its own configuration-chain controller. Successor to the fixed frac_lut4 tile.
//  Config bits shift in serially on the ccff chain into a shadow register, tracked by a bit counter.
//  The shadow register is committed atomically to an active register only when a full frame has arrived, so the LUT
//  never evaluates a half-loaded truth table. Sits in the CLB fle/fabric level, chained head->tail with neighbour tiles.
// PARAMETERS
//  K         4   number of LUT inputs (K>=3); truth table has 2**K bits
//  MODE_BITS 1   fracture-mode bits; bit0=1 selects fractured operation
//  L (local) 2**K+MODE_BITS(+1 if CFG_PARITY_EN)   frame length in bits; counter width $clog2(L+1)
// PORTS
//  prog_clk     in   1      config/LUT clock; all state updates on rising edge
//  prog_rst_n   in   1      reset, synchronous, active-low
//  ccff_en      in   1      shift enable: one chain bit accepted per cycle when high
//  ccff_clr     in   1      synchronous frame restart: clears shadow and counter, keeps active
//  ccff_head    in   1      serial config input
//  ccff_tail    out  1      serial config output = shadow[L-1] (registered)
//  lut_in       in   K      LUT inputs; lut_in[0] is the LSB of the table index
//  lut_km2_out  out  2      (K-2)-input LUT taps: lower/upper quarter of stage K-2
//  lut_km1_out  out  2      (K-1)-input LUT outputs: [0] sram[0..2**(K-1)-1], [1] upper half
//  lut_k_out    out  1      K-input LUT output
//  cfg_valid    out  1      active register holds a committed frame
//  cfg_busy     out  1      counter nonzero (frame partially shifted)
//  cfg_err      out  1      sticky frame error (parity build only, else tied 0)
// BEHAVIOUR
//  Reset (prog_rst_n=0 at edge): shadow, active, counter -> 0; cfg_valid=0, cfg_busy=0, cfg_err=0, ccff_tail=0.
//  Shift: if ccff_en & !ccff_clr: shadow <= {shadow[L-2:0], ccff_head}; cnt <= cnt+1.
//  Commit: on the edge where cnt==L-1 and a bit shifts, active <= new shadow value; cnt <= 0; cfg_valid <= 1 next cycle.
//   The shadow register is not cleared after a commit. ccff_tail therefore keeps passing data to downstream tiles.
//  ccff_en low: hold counter and shadow (pause mid-frame; no timeout).
//  ccff_clr: cnt <= 0, shadow <= 0; active and cfg_valid are unchanged. clr has priority over en on the same edge.
//  Reset has priority over everything; reset mid-frame discards the partial frame and the active frame.
//  Field map after commit: sram[i]=shadow[i] for i<2**K, mode=shadow[2**K], parity=shadow[2**K+1].
//   So the first bit shifted is parity/mode, and the last bit shifted is sram[0].
//  LUT evaluation is combinational from active: lut_k_out = sram[lut_in].
//   Stage taps follow the mux tree: km1[h] indexes with lut_in[K-2:0] into half h; km2[q] uses lut_in[K-3:0] in quarter q (q=0,1).
//  Fracture: mode=1 forces lut_in[K-1] to 0 at the final stage, so lut_k_out == lut_km1_out[0].
//  Gating: while cfg_valid=0 all LUT outputs are 0. Commit latency: the outputs reflect the new table one edge after the final shift.
//  cfg_busy = (cnt != 0).
// CONFIGURATION
//  Macro CFG_PARITY_EN:
//   defined: L gains one parity bit. The frame must have even parity over all L bits. On a mismatch at commit time:
//    no commit; active and cfg_valid are unchanged; cnt -> 0; cfg_err <= 1.
//    cfg_err clears on the next successful commit, on ccff_clr, or on reset.
//   undefined: there is no parity bit; cfg_err is tied to 0; every full frame commits.
// STRUCTURE
//  Package frac_lut_pkg: function lut_frame_len(K,MODE_BITS) and localparam MODE_FRACTURE_BIT=0.
//  Sub-module frac_lutk_mux: a purely combinational parametrised mux tree (sram, mode, in -> taps).
//  The top level holds the shadow, counter, commit and parity logic.
// TESTING
//  1 Reset, no shifting, lut_in=4'hF -> all outputs 0, cfg_valid=0, cfg_busy=0.
//  2 K=4: shift mode=0 then sram=16'h8000, with sram[0] last (17 bits) -> cfg_valid=1 one edge later.
//    lut_in=4'hF -> lut_k_out=1; lut_in=4'hE -> 0.
//  3 Drop ccff_en for 5 cycles after 8 bits, then finish the frame -> same result as test 2; cfg_busy=1 during the pause.
//  4 Table 16'h8000 committed; load 9 bits of a new frame, pulse ccff_clr -> cnt=0, lut_k_out still 1 for lut_in=F.
//  5 Frame mode=1, sram=16'h00FF, lut_in=4'b1010 -> lut_km1_out=2'b01, lut_k_out=1 (in[3] ignored).
//  6 CFG_PARITY_EN: a frame with odd parity -> cfg_err=1, previous table kept. A following correct frame -> cfg_err=0.

Source files
------------

// File: rtl/frac_lutk_cfg_pkg.sv
// Shared definitions for the fracturable K-input LUT tile.
// Optional build macro: CFG_PARITY_EN adds one even-parity bit to each config frame.
package frac_lut_pkg;

    // Bit of the mode field that selects fractured operation.
    localparam int MODE_FRACTURE_BIT = 0;

    // Config frame length: truth table + mode field (+ parity bit when enabled).
    function automatic int lut_frame_len(input int k, input int mode_bits);
`ifdef CFG_PARITY_EN
        return (1 << k) + mode_bits + 1;
`else
        return (1 << k) + mode_bits;
`endif
    endfunction

endpackage

// File: rtl/frac_lutk_cfg_if.sv
// Config-chain and LUT signal bundle for frac_lutk_cfg.
// master = driver of chain/LUT inputs, slave = the LUT tile.
interface frac_lutk_cfg_if #(
    parameter int K = 4
);
    logic         ccff_en;
    logic         ccff_clr;
    logic         ccff_head;
    logic         ccff_tail;
    logic [K-1:0] lut_in;
    logic [1:0]   lut_km2_out;
    logic [1:0]   lut_km1_out;
    logic         lut_k_out;
    logic         cfg_valid;
    logic         cfg_busy;
    logic         cfg_err;

    modport master (
        output ccff_en, ccff_clr, ccff_head, lut_in,
        input  ccff_tail, lut_km2_out, lut_km1_out, lut_k_out,
               cfg_valid, cfg_busy, cfg_err
    );

    modport slave (
        input  ccff_en, ccff_clr, ccff_head, lut_in,
        output ccff_tail, lut_km2_out, lut_km1_out, lut_k_out,
               cfg_valid, cfg_busy, cfg_err
    );
endinterface

// File: rtl/frac_lutk_mux.sv
// Combinational K-input LUT mux tree with stage taps.
// Fractured mode forces the top select bit low so the K output equals the lower (K-1) LUT.
module frac_lutk_mux #(
    parameter int K = 4
) (
    input  logic [(1<<K)-1:0] i_sram,
    input  logic              i_mode,
    input  logic [K-1:0]      i_in,
    output logic [1:0]        o_km2,
    output logic [1:0]        o_km1,
    output logic              o_k
);
    // (K-2) taps: quarters 0 and 1 of the table
    assign o_km2[0] = i_sram[{1'b0, 1'b0, i_in[K-3:0]}];
    assign o_km2[1] = i_sram[{1'b0, 1'b1, i_in[K-3:0]}];

    // (K-1) outputs: lower and upper half of the table
    assign o_km1[0] = i_sram[{1'b0, i_in[K-2:0]}];
    assign o_km1[1] = i_sram[{1'b1, i_in[K-2:0]}];

    // Final stage: top select suppressed in fractured mode
    assign o_k = i_sram[{i_in[K-1] & ~i_mode, i_in[K-2:0]}];
endmodule

// File: rtl/frac_lutk_cfg.sv
// Fracturable K-input LUT with serial config-chain controller.
// Bits shift into a shadow register; a full frame is committed atomically to the active table.
// Optional build macro: CFG_PARITY_EN (even-parity frame check with sticky cfg_err).
module frac_lutk_cfg
    import frac_lut_pkg::*;
#(
    parameter int K         = 4,
    parameter int MODE_BITS = 1
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    frac_lutk_cfg_if.slave    bus
);
    localparam int N  = 1 << K;
    localparam int L  = lut_frame_len(K, MODE_BITS);
    localparam int A  = N + MODE_BITS;
    localparam int CW = $clog2(L + 1);

    logic [L-1:0]  r_shadow;
    logic [A-1:0]  r_active;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic [L-1:0]  w_shift_next;
    logic          w_last;
    logic          w_par_ok;
    logic [1:0]    w_km2;
    logic [1:0]    w_km1;
    logic          w_k;

    assign w_shift_next = {r_shadow[L-2:0], bus.ccff_head};
    assign w_last       = bus.ccff_en && !bus.ccff_clr && (r_cnt == CW'(L - 1));

`ifdef CFG_PARITY_EN
    assign w_par_ok = ~(^w_shift_next);
`else
    assign w_par_ok = 1'b1;
`endif

    // Shadow shift, bit counter and atomic commit of a complete frame
    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else if (bus.ccff_clr) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (bus.ccff_en) begin
            r_shadow <= w_shift_next;
            if (w_last) begin
                r_cnt <= '0;
                if (w_par_ok) begin
                    r_active <= w_shift_next[A-1:0];
                    r_valid  <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

`ifdef CFG_PARITY_EN
    logic r_err;

    // Sticky parity error: set on a bad frame, cleared by a good commit, clr or reset
    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            r_err <= 1'b0;
        end else if (bus.ccff_clr) begin
            r_err <= 1'b0;
        end else if (w_last) begin
            r_err <= ~w_par_ok;
        end
    end

    assign bus.cfg_err = r_err;
`else
    assign bus.cfg_err = 1'b0;
`endif

    frac_lutk_mux #(.K(K)) u_mux (
        .i_sram (r_active[N-1:0]),
        .i_mode (r_active[N + MODE_FRACTURE_BIT]),
        .i_in   (bus.lut_in),
        .o_km2  (w_km2),
        .o_km1  (w_km1),
        .o_k    (w_k)
    );

    // Outputs stay low until a frame has been committed
    assign bus.lut_km2_out = r_valid ? w_km2 : 2'b00;
    assign bus.lut_km1_out = r_valid ? w_km1 : 2'b00;
    assign bus.lut_k_out   = r_valid & w_k;
    assign bus.cfg_valid   = r_valid;
    assign bus.cfg_busy    = (r_cnt != '0);
    assign bus.ccff_tail   = r_shadow[L-1];
endmodule

// File: tb/tb_frac_lutk_cfg.sv
// Self-checking bench for frac_lutk_cfg (K=4, MODE_BITS=1); honours CFG_PARITY_EN.
module tb_frac_lutk_cfg;
    localparam int K = 4;
`ifdef CFG_PARITY_EN
    localparam int L = 18;
`else
    localparam int L = 17;
`endif

    logic prog_clk   = 1'b0;
    logic prog_rst_n = 1'b0;

    frac_lutk_cfg_if #(.K(K)) bus();

    frac_lutk_cfg #(.K(K), .MODE_BITS(1)) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .bus        (bus)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [L-1:0] m_shadow;
    logic [15:0]  m_sram;
    logic         m_mode;
    logic         m_valid;
    logic         m_err;
    int           m_cnt;

    task automatic push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [7:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h required=entry", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [4:0] model_lut(input logic [3:0] in);
        logic [1:0] km2, km1;
        logic       k;
        if (!m_valid) return 5'b0;
        km2[0] = m_sram[{2'b00, in[1:0]}];
        km2[1] = m_sram[{2'b01, in[1:0]}];
        km1[0] = m_sram[{1'b0, in[2:0]}];
        km1[1] = m_sram[{1'b1, in[2:0]}];
        k      = m_mode ? km1[0] : m_sram[in];
        return {km2, km1, k};
    endfunction

    function automatic logic [L-1:0] mk_frame(input logic [15:0] sram, input logic mode);
        logic [L-1:0] f;
        f        = '0;
        f[15:0]  = sram;
        f[16]    = mode;
`ifdef CFG_PARITY_EN
        f[17]    = ^{mode, sram};
`endif
        return f;
    endfunction

    // Compare every observable output against the model
    task automatic check_state(input string tag);
        push({tag, "_lut"},   {3'b0, model_lut(bus.lut_in)});
        push({tag, "_valid"}, {7'b0, m_valid});
        push({tag, "_busy"},  {7'b0, (m_cnt != 0)});
        push({tag, "_err"},   {7'b0, m_err});
        push({tag, "_tail"},  {7'b0, m_shadow[L-1]});
        pop_cmp({3'b0, bus.lut_km2_out, bus.lut_km1_out, bus.lut_k_out});
        pop_cmp({7'b0, bus.cfg_valid});
        pop_cmp({7'b0, bus.cfg_busy});
        pop_cmp({7'b0, bus.cfg_err});
        pop_cmp({7'b0, bus.ccff_tail});
    endtask

    task automatic check_const(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        push(tag, exp);
        pop_cmp(obs);
    endtask

    // One clock edge with given chain controls; model updated at the edge
    task automatic cyc(input logic en, input logic clr, input logic head);
        logic [L-1:0] nxt;
        logic         par_ok;
        bus.ccff_en   = en;
        bus.ccff_clr  = clr;
        bus.ccff_head = head;
        @(posedge prog_clk);
        nxt = {m_shadow[L-2:0], head};
`ifdef CFG_PARITY_EN
        par_ok = ~(^nxt);
`else
        par_ok = 1'b1;
`endif
        if (clr) begin
            m_shadow = '0;
            m_cnt    = 0;
            m_err    = 1'b0;
        end else if (en) begin
            if (m_cnt == L - 1) begin
                m_cnt = 0;
                if (par_ok) begin
                    m_sram  = nxt[15:0];
                    m_mode  = nxt[16];
                    m_valid = 1'b1;
                    m_err   = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_shadow = nxt;
        end
        #1;
        bus.ccff_en  = 1'b0;
        bus.ccff_clr = 1'b0;
    endtask

    task automatic shift_range(input logic [L-1:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) cyc(1'b1, 1'b0, f[i]);
    endtask

    task automatic do_reset();
        prog_rst_n = 1'b0;
        @(posedge prog_clk);
        m_shadow = '0; m_sram = '0; m_mode = 1'b0;
        m_valid  = 1'b0; m_err = 1'b0; m_cnt = 0;
        #1;
        prog_rst_n = 1'b1;
    endtask

    initial begin
        logic [L-1:0] f;
        bus.ccff_en = 1'b0; bus.ccff_clr = 1'b0; bus.ccff_head = 1'b0;
        bus.lut_in  = 4'hF;
        m_shadow = '0; m_sram = '0; m_mode = 1'b0;
        m_valid  = 1'b0; m_err = 1'b0; m_cnt = 0;

        // 1: reset state
        @(posedge prog_clk);
        do_reset();
        check_state("t1_reset");
        check_const("t1_k", {7'b0, bus.lut_k_out}, 8'd0);

        // 2: table 8000, mode 0
        f = mk_frame(16'h8000, 1'b0);
        shift_range(f, L - 1, 1);
        check_state("t2_pre");
        check_const("t2_pre_valid", {7'b0, bus.cfg_valid}, 8'd0);
        shift_range(f, 0, 0);
        check_state("t2_commit");
        check_const("t2_k_F", {7'b0, bus.lut_k_out}, 8'd1);
        bus.lut_in = 4'hE; #1;
        check_const("t2_k_E", {7'b0, bus.lut_k_out}, 8'd0);
        check_state("t2_E");

        // 3: pause mid-frame
        do_reset();
        bus.lut_in = 4'hF;
        shift_range(f, L - 1, L - 8);
        for (int p = 0; p < 5; p++) begin
            cyc(1'b0, 1'b0, 1'b1);
            check_state("t3_pause");
            check_const("t3_busy", {7'b0, bus.cfg_busy}, 8'd1);
        end
        shift_range(f, L - 9, 0);
        check_state("t3_done");
        check_const("t3_k_F", {7'b0, bus.lut_k_out}, 8'd1);

        // 4: partial frame abandoned by clr (clr asserted together with en)
        f = mk_frame(16'h0000, 1'b0);
        shift_range(f, L - 1, L - 9);
        check_state("t4_partial");
        cyc(1'b1, 1'b1, 1'b1);
        check_state("t4_clr");
        check_const("t4_busy", {7'b0, bus.cfg_busy}, 8'd0);
        check_const("t4_k_F", {7'b0, bus.lut_k_out}, 8'd1);

        // 5: fractured mode
        f = mk_frame(16'h00FF, 1'b1);
        shift_range(f, L - 1, 0);
        bus.lut_in = 4'b1010; #1;
        check_state("t5_frac");
        check_const("t5_km1", {6'b0, bus.lut_km1_out}, 8'h01);
        check_const("t5_k", {7'b0, bus.lut_k_out}, 8'd1);
        check_const("t5_tail", {7'b0, bus.ccff_tail}, {7'b0, f[L-1]});
        bus.lut_in = 4'b0111; #1;
        check_state("t5_in7");

`ifdef CFG_PARITY_EN
        // 6: bad parity keeps old table and sets err; clr and good commit clear it
        f = mk_frame(16'h0000, 1'b0);
        f[17] = ~f[17];
        bus.lut_in = 4'b1010;
        shift_range(f, L - 1, 0);
        check_state("t6_bad");
        check_const("t6_err", {7'b0, bus.cfg_err}, 8'd1);
        check_const("t6_keep", {7'b0, bus.lut_k_out}, 8'd1);
        cyc(1'b0, 1'b1, 1'b0);
        check_const("t6_clr_err", {7'b0, bus.cfg_err}, 8'd0);
        shift_range(f, L - 1, 0);
        check_const("t6_err2", {7'b0, bus.cfg_err}, 8'd1);
        f = mk_frame(16'h0000, 1'b0);
        shift_range(f, L - 1, 0);
        check_state("t6_good");
        check_const("t6_err_clr", {7'b0, bus.cfg_err}, 8'd0);
        check_const("t6_k_new", {7'b0, bus.lut_k_out}, 8'd0);
`endif

        // Reset mid-frame discards partial and active frames
        f = mk_frame(16'hFFFF, 1'b0);
        shift_range(f, L - 1, L - 4);
        do_reset();
        bus.lut_in = 4'hF; #1;
        check_state("t7_rst");
        check_const("t7_valid", {7'b0, bus.cfg_valid}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
